// File: rtl/alu_rr_arbiter_pkg.sv
// Shared ALU control-code definitions and the legal-code check used by the
// ALU datapath and by anything else that decodes ALU control codes.
package alu_rr_arbiter_pkg;

    localparam int unsigned ALU_AND = 0;
    localparam int unsigned ALU_OR  = 1;
    localparam int unsigned ALU_ADD = 2;
    localparam int unsigned ALU_SUB = 6;
    localparam int unsigned ALU_SLT = 7;
    localparam int unsigned ALU_NOR = 12;

    // True when the code selects one of the implemented operations.
    function automatic logic ctrl_is_legal(input int unsigned code);
        case (code)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: return 1'b1;
            default:                                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_rr_arbiter_alu.sv
// Combinational ALU shared by both requesters. Unsupported control codes
// produce a zero result and raise the illegal flag.
module alu_rr_arbiter_alu
    import alu_rr_arbiter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
) (
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              illegal
);

    logic [31:0] code;

    assign code = 32'(ctrl);

    // Operation select; ADD/SUB wrap, SLT is an unsigned compare.
    always_comb begin
        result  = '0;
        illegal = !ctrl_is_legal(code);
        case (code)
            ALU_AND: result = src1 & src2;
            ALU_OR:  result = src1 | src2;
            ALU_ADD: result = src1 + src2;
            ALU_SUB: result = src1 - src2;
            ALU_SLT: result = DATA_W'(src1 < src2);
            ALU_NOR: result = ~(src1 | src2);
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters.
// The granted operation is evaluated combinationally and captured into a
// single-entry response slot tagged with the requester ID.
module alu_rr_arbiter
    import alu_rr_arbiter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [DATA_W-1:0] req0_src1_i,
    input  logic [DATA_W-1:0] req0_src2_i,
    input  logic [CTRL_W-1:0] req0_ctrl_i,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [DATA_W-1:0] req1_src1_i,
    input  logic [DATA_W-1:0] req1_src2_i,
    input  logic [CTRL_W-1:0] req1_ctrl_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic              rsp_id_o,
    output logic [DATA_W-1:0] rsp_result_o,
    output logic              rsp_zero_o,
    output logic              rsp_illegal_o
);

    logic              slot_free;
    logic              grant_valid;
    logic              grant_id;
    logic              transfer;
    logic              last_grant;

    logic [DATA_W-1:0] alu_src1_p0;
    logic [DATA_W-1:0] alu_src2_p0;
    logic [CTRL_W-1:0] alu_ctrl_p0;
    logic [DATA_W-1:0] alu_result_p0;
    logic              alu_zero_p0;
    logic              alu_illegal_p0;

    logic              rsp_valid_p1;
    logic              rsp_id_p1;
    logic [DATA_W-1:0] rsp_result_p1;
    logic              rsp_zero_p1;
    logic              rsp_illegal_p1;

    // The slot can accept a new result if it is empty or being drained now.
    assign slot_free = !rsp_valid_p1 || rsp_ready_i;

    // Round-robin grant: a lone requester wins, a tie goes to the one not
    // served last. No grant at all while the slot is backpressured.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (slot_free) begin
            if (req0_valid_i && req1_valid_i) begin
                grant_valid = 1'b1;
                grant_id    = ~last_grant;
            end else if (req0_valid_i) begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end else if (req1_valid_i) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
        end
    end

    assign req0_ready_o = grant_valid && !grant_id;
    assign req1_ready_o = grant_valid &&  grant_id;
    assign transfer     = (req0_valid_i && req0_ready_o) ||
                          (req1_valid_i && req1_ready_o);

    // Stage p0: operand mux feeding the shared ALU (requester 0 when idle).
    assign alu_src1_p0 = grant_id ? req1_src1_i : req0_src1_i;
    assign alu_src2_p0 = grant_id ? req1_src2_i : req0_src2_i;
    assign alu_ctrl_p0 = grant_id ? req1_ctrl_i : req0_ctrl_i;

    alu_rr_arbiter_alu #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_alu (
        .src1    (alu_src1_p0),
        .src2    (alu_src2_p0),
        .ctrl    (alu_ctrl_p0),
        .result  (alu_result_p0),
        .zero    (alu_zero_p0),
        .illegal (alu_illegal_p0)
    );

    // Stage p0 -> p1: capture the ALU output into the response slot on a
    // transfer (overwriting a slot drained in the same cycle), otherwise
    // clear valid on drain and hold everything under backpressure.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rsp_valid_p1   <= 1'b0;
            rsp_id_p1      <= 1'b0;
            rsp_result_p1  <= '0;
            rsp_zero_p1    <= 1'b0;
            rsp_illegal_p1 <= 1'b0;
            last_grant     <= 1'b1;
        end else if (transfer) begin
            rsp_valid_p1   <= 1'b1;
            rsp_id_p1      <= grant_id;
            rsp_result_p1  <= alu_result_p0;
            rsp_zero_p1    <= alu_zero_p0;
            rsp_illegal_p1 <= alu_illegal_p0;
            last_grant     <= grant_id;
        end else if (rsp_ready_i) begin
            rsp_valid_p1   <= 1'b0;
        end
    end

    assign rsp_valid_o   = rsp_valid_p1;
    assign rsp_id_o      = rsp_id_p1;
    assign rsp_result_o  = rsp_result_p1;
    assign rsp_zero_o    = rsp_zero_p1;
    assign rsp_illegal_o = rsp_illegal_p1;

endmodule
